// File: rtl/brq_pkg.sv
// Shared definitions for the core-to-data-memory bridge: FSM states,
// func3 size codes, strobe width and size-code classification helpers.
package brq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } brq_state_e;

  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  localparam int STRB_W = 4;

  // Byte-sized access (signed or unsigned)
  function automatic logic sz_is_byte(input logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_BU);
  endfunction

  // Half-sized access (signed or unsigned)
  function automatic logic sz_is_half(input logic [2:0] sz);
    return (sz == SZ_H) || (sz == SZ_HU);
  endfunction

  // Loads that sign-extend; every other code zero-extends or is a word
  function automatic logic sz_is_signed(input logic [2:0] sz);
    return (sz == SZ_B) || (sz == SZ_H);
  endfunction

endpackage

// File: rtl/brq_lsu_align.sv
// Lane steering for the bridge: load lane select with sign/zero extension,
// store data replication and byte strobe generation. Purely combinational.
// Any size code that is not a byte or half code is handled as a word.
module brq_lsu_align
  import brq_pkg::*;
#(
  parameter int DataWidth = 32
) (
  input  logic [1:0]           i_addr_lo,
  input  logic [2:0]           i_size,
  input  logic [DataWidth-1:0] i_wdata,
  input  logic [DataWidth-1:0] i_rdata,
  output logic [DataWidth-1:0] o_wdata,
  output logic [STRB_W-1:0]    o_wstrb,
  output logic [DataWidth-1:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_sign;

  // Load path: pick the addressed lane, then extend to full width
  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
    w_sign = sz_is_signed(i_size);
    if (sz_is_byte(i_size)) begin
      o_rdata = {{(DataWidth-8){w_sign & w_byte[7]}}, w_byte};
    end else if (sz_is_half(i_size)) begin
      o_rdata = {{(DataWidth-16){w_sign & w_half[15]}}, w_half};
    end else begin
      o_rdata = i_rdata;
    end
  end

  // Store path: replicate data across lanes and raise the addressed strobes
  always_comb begin
    if (sz_is_byte(i_size)) begin
      o_wdata = {4{i_wdata[7:0]}};
      o_wstrb = 4'b0001 << i_addr_lo;
    end else if (sz_is_half(i_size)) begin
      o_wdata = {2{i_wdata[15:0]}};
      o_wstrb = i_addr_lo[1] ? 4'b1100 : 4'b0011;
    end else begin
      o_wdata = i_wdata;
      o_wstrb = 4'b1111;
    end
  end

endmodule

// File: rtl/brq_dmem_bridge.sv
// Core load/store port to single-cycle-ack data memory bridge.
// One outstanding access; IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
// A bounded wait turns a missing mem_ack into a one-cycle bus_err pulse.
// Optional macro BRQ_DMEM_MISALIGN_TRAP_EN: misaligned half/word accesses
// complete immediately with bus_err instead of touching memory.
module brq_dmem_bridge
  import brq_pkg::*;
#(
  parameter int DataWidth     = 32,
  parameter int AddrWidth     = 15,
  parameter int TimeoutCycles = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst,
  input  logic [AddrWidth-1:0] core_addr,
  input  logic [DataWidth-1:0] core_wdata,
  input  logic                 core_ren,
  input  logic                 core_wen,
  input  logic [2:0]           core_byte_en,
  output logic [DataWidth-1:0] core_rdata,
  output logic                 core_stall,
  output logic                 bus_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [AddrWidth-3:0] mem_addr,
  output logic [STRB_W-1:0]    mem_wstrb,
  output logic [DataWidth-1:0] mem_wdata,
  input  logic [DataWidth-1:0] mem_rdata,
  input  logic                 mem_ack
);

  localparam logic [7:0] TO_LAST = 8'(TimeoutCycles - 1);

  brq_state_e           r_state;
  logic [1:0]           r_addr_lo;
  logic [2:0]           r_size;
  logic [7:0]           r_cnt;
  logic                 r_mem_req;
  logic                 r_mem_we;
  logic [AddrWidth-3:0] r_mem_addr;
  logic [STRB_W-1:0]    r_mem_wstrb;
  logic [DataWidth-1:0] r_mem_wdata;
  logic [DataWidth-1:0] r_rdata;
  logic                 r_bus_err;

  logic                 w_req;
  logic                 w_misalign;
  logic [1:0]           w_addr_lo;
  logic [2:0]           w_size;
  logic [DataWidth-1:0] w_wdata_rep;
  logic [STRB_W-1:0]    w_wstrb;
  logic [DataWidth-1:0] w_rdata_ext;

  assign w_req = core_ren | core_wen;

  // The aligner sees the live core request in IDLE (store setup) and the
  // latched address/size afterwards (load extension at ack time).
  assign w_addr_lo = (r_state == IDLE) ? core_addr[1:0] : r_addr_lo;
  assign w_size    = (r_state == IDLE) ? core_byte_en   : r_size;

`ifdef BRQ_DMEM_MISALIGN_TRAP_EN
  assign w_misalign = sz_is_half(core_byte_en) ? core_addr[0]
                    : (!sz_is_byte(core_byte_en) && (core_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  brq_lsu_align #(
    .DataWidth(DataWidth)
  ) u_align (
    .i_addr_lo(w_addr_lo),
    .i_size   (w_size),
    .i_wdata  (core_wdata),
    .i_rdata  (mem_rdata),
    .o_wdata  (w_wdata_rep),
    .o_wstrb  (w_wstrb),
    .o_rdata  (w_rdata_ext)
  );

  // Stall covers the accepting IDLE cycle and the whole memory phase
  always_comb begin
    core_stall = (r_state == REQ) || (r_state == WAIT) ||
                 ((r_state == IDLE) && w_req);
  end

  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wstrb  = r_mem_wstrb;
  assign mem_wdata  = r_mem_wdata;
  assign core_rdata = r_rdata;
  assign bus_err    = r_bus_err;

  // Access sequencer with registered memory-side and response outputs
  always_ff @(posedge brq_clk or posedge brq_rst) begin
    if (brq_rst) begin
      r_state     <= IDLE;
      r_addr_lo   <= 2'b00;
      r_size      <= 3'b000;
      r_cnt       <= 8'd0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wstrb <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_bus_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req && w_misalign) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b1;
            r_state   <= DONE;
          end else if (w_req) begin
            // A simultaneous ren/wen is a store
            r_addr_lo   <= core_addr[1:0];
            r_size      <= core_byte_en;
            r_cnt       <= 8'd0;
            r_mem_req   <= 1'b1;
            r_mem_we    <= core_wen;
            r_mem_addr  <= core_addr[AddrWidth-1:2];
            r_mem_wstrb <= core_wen ? w_wstrb : '0;
            r_mem_wdata <= w_wdata_rep;
            r_state     <= REQ;
          end
        end
        REQ, WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (mem_ack) begin
            r_rdata   <= w_rdata_ext;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else if (r_cnt == TO_LAST) begin
            r_rdata   <= '0;
            r_bus_err <= 1'b1;
            r_mem_req <= 1'b0;
            r_state   <= DONE;
          end else begin
            r_state <= WAIT;
          end
        end
        DONE: begin
          // Response is only meaningful for the single DONE cycle
          r_rdata   <= '0;
          r_bus_err <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_brq_dmem_bridge.sv
// Directed bench for brq_dmem_bridge: loads with extension, replicated
// stores, timeout error, reset mid-access and the misaligned word case
// (expectations follow BRQ_DMEM_MISALIGN_TRAP_EN when it is defined).
module tb_brq_dmem_bridge;

  logic        clk;
  logic        rst;
  logic [14:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_ren;
  logic        core_wen;
  logic [2:0]  core_byte_en;
  logic [31:0] core_rdata;
  logic        core_stall;
  logic        bus_err;
  logic        mem_req;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  int n_cmp = 0;
  int n_mis = 0;

  brq_dmem_bridge #(
    .DataWidth(32),
    .AddrWidth(15),
    .TimeoutCycles(15)
  ) dut (
    .brq_clk     (clk),
    .brq_rst     (rst),
    .core_addr   (core_addr),
    .core_wdata  (core_wdata),
    .core_ren    (core_ren),
    .core_wen    (core_wen),
    .core_byte_en(core_byte_en),
    .core_rdata  (core_rdata),
    .core_stall  (core_stall),
    .bus_err     (bus_err),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wstrb   (mem_wstrb),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ack     (mem_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present a request in IDLE, confirm the combinational stall, then
  // advance one edge and withdraw the request.
  task automatic start(input logic ren, input logic wen, input logic [14:0] addr,
                       input logic [2:0] size, input logic [31:0] wdata);
    core_ren     = ren;
    core_wen     = wen;
    core_addr    = addr;
    core_byte_en = size;
    core_wdata   = wdata;
    #1;
    chk("stall_idle_req", {31'd0, core_stall}, 32'd1);
    tick();
    core_ren = 1'b0;
    core_wen = 1'b0;
  endtask

  // Let the memory answer after 'delay' un-acked cycles; ends in DONE
  task automatic respond(input int delay, input logic [31:0] rdata);
    mem_ack = 1'b0;
    for (int i = 0; i < delay; i++) tick();
    mem_ack   = 1'b1;
    mem_rdata = rdata;
    tick();
    mem_ack = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    core_addr = '0; core_wdata = '0; core_ren = 1'b0; core_wen = 1'b0;
    core_byte_en = 3'b010; mem_rdata = '0; mem_ack = 1'b0;
    tick(); tick();
    chk("rst_mem_req",   {31'd0, mem_req},    32'd0);
    chk("rst_mem_we",    {31'd0, mem_we},     32'd0);
    chk("rst_mem_wstrb", {28'd0, mem_wstrb},  32'd0);
    chk("rst_mem_addr",  {19'd0, mem_addr},   32'd0);
    chk("rst_mem_wdata", mem_wdata,           32'd0);
    chk("rst_rdata",     core_rdata,          32'd0);
    chk("rst_bus_err",   {31'd0, bus_err},    32'd0);
    chk("rst_stall",     {31'd0, core_stall}, 32'd0);
    rst = 1'b0;
    tick();

    // LW 0x0010, zero-wait memory
    start(1'b1, 1'b0, 15'h0010, 3'b010, 32'h0);
    chk("lw_req",       {31'd0, mem_req},    32'd1);
    chk("lw_addr",      {19'd0, mem_addr},   32'h0004);
    chk("lw_we",        {31'd0, mem_we},     32'd0);
    chk("lw_wstrb",     {28'd0, mem_wstrb},  32'd0);
    chk("lw_stall_req", {31'd0, core_stall}, 32'd1);
    respond(0, 32'hDEADBEEF);
    chk("lw_rdata",     core_rdata,          32'hDEADBEEF);
    chk("lw_stall_done",{31'd0, core_stall}, 32'd0);
    chk("lw_req_done",  {31'd0, mem_req},    32'd0);
    chk("lw_err",       {31'd0, bus_err},    32'd0);
    $display("LW   @0010 -> %h", core_rdata);
    tick();

    // Byte and half loads with sign/zero extension
    start(1'b1, 1'b0, 15'h0013, 3'b000, 32'h0);
    respond(0, 32'h80FF_0000);
    chk("lb_rdata", core_rdata, 32'hFFFFFF80);
    $display("LB   @0013 -> %h", core_rdata);
    tick();
    start(1'b1, 1'b0, 15'h0013, 3'b100, 32'h0);
    respond(0, 32'h80FF_0000);
    chk("lbu_rdata", core_rdata, 32'h00000080);
    $display("LBU  @0013 -> %h", core_rdata);
    tick();
    start(1'b1, 1'b0, 15'h0012, 3'b001, 32'h0);
    respond(1, 32'h80FF_0000);
    chk("lh_rdata", core_rdata, 32'hFFFF80FF);
    $display("LH   @0012 -> %h", core_rdata);
    tick();
    start(1'b1, 1'b0, 15'h0012, 3'b101, 32'h0);
    respond(0, 32'h80FF_0000);
    chk("lhu_rdata", core_rdata, 32'h000080FF);
    $display("LHU  @0012 -> %h", core_rdata);
    tick();
    start(1'b1, 1'b0, 15'h0011, 3'b000, 32'h0);
    respond(0, 32'h12345678);
    chk("lb_pos_rdata", core_rdata, 32'h00000056);
    $display("LB   @0011 -> %h", core_rdata);
    tick();

    // SH 0x0022, ack arrives in WAIT
    start(1'b0, 1'b1, 15'h0022, 3'b001, 32'h0000ABCD);
    chk("sh_wstrb", {28'd0, mem_wstrb}, 32'b1100);
    chk("sh_wdata", mem_wdata,          32'hABCDABCD);
    chk("sh_we",    {31'd0, mem_we},    32'd1);
    chk("sh_addr",  {19'd0, mem_addr},  32'h0008);
    tick();
    chk("sh_wait_req",   {31'd0, mem_req},    32'd1);
    chk("sh_wait_stall", {31'd0, core_stall}, 32'd1);
    chk("sh_wait_wstrb", {28'd0, mem_wstrb},  32'b1100);
    respond(0, 32'h0);
    chk("sh_stall_done", {31'd0, core_stall}, 32'd0);
    $display("SH   @0022 wstrb=%b wdata=%h", 4'b1100, 32'hABCDABCD);
    tick();

    // ren and wen together behave as a store (SB @0021)
    start(1'b1, 1'b1, 15'h0021, 3'b000, 32'h000000A5);
    chk("sb_we",    {31'd0, mem_we},    32'd1);
    chk("sb_wstrb", {28'd0, mem_wstrb}, 32'b0010);
    chk("sb_wdata", mem_wdata,          32'hA5A5A5A5);
    respond(0, 32'h0);
    $display("SB   @0021 (ren+wen) wstrb=%b", mem_wstrb);
    tick();

    // Undefined size code 011 is a word store
    start(1'b0, 1'b1, 15'h0030, 3'b011, 32'h01020304);
    chk("sw_undef_wstrb", {28'd0, mem_wstrb}, 32'b1111);
    chk("sw_undef_wdata", mem_wdata,          32'h01020304);
    respond(0, 32'h0);
    $display("S?   @0030 size=011 wstrb=%b", mem_wstrb);
    tick();

    // Memory never acks: 15 cycles of mem_req, then error in DONE
    mem_rdata = 32'h12345678;
    start(1'b1, 1'b0, 15'h0000, 3'b010, 32'h0);
    n = 0;
    while (mem_req === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to_cycles", n,                   32'd15);
    chk("to_err",    {31'd0, bus_err},    32'd1);
    chk("to_rdata",  core_rdata,          32'd0);
    chk("to_stall",  {31'd0, core_stall}, 32'd0);
    tick();
    chk("to_err_pulse", {31'd0, bus_err}, 32'd0);
    $display("LW   @0000 timeout after %0d cycles", n);

    // Reset while in WAIT, late ack afterwards
    start(1'b1, 1'b0, 15'h0040, 3'b010, 32'h0);
    tick();
    chk("rw_wait_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rw_req_async",  {31'd0, mem_req},    32'd0);
    chk("rw_stall",      {31'd0, core_stall}, 32'd0);
    chk("rw_addr_async", {19'd0, mem_addr},   32'd0);
    tick();
    rst = 1'b0;
    mem_ack = 1'b1;
    mem_rdata = 32'h55AA55AA;
    tick();
    chk("rw_late_req",   {31'd0, mem_req},    32'd0);
    chk("rw_late_err",   {31'd0, bus_err},    32'd0);
    chk("rw_late_rdata", core_rdata,          32'd0);
    tick();
    mem_ack = 1'b0;
    chk("rw_late_rdata2", core_rdata,         32'd0);
    chk("rw_late_stall",  {31'd0, core_stall}, 32'd0);
    $display("RST  in WAIT -> idle, late ack ignored");

    // Misaligned LW @0011
    start(1'b1, 1'b0, 15'h0011, 3'b010, 32'h0);
`ifdef BRQ_DMEM_MISALIGN_TRAP_EN
    chk("mis_req",   {31'd0, mem_req},    32'd0);
    chk("mis_err",   {31'd0, bus_err},    32'd1);
    chk("mis_rdata", core_rdata,          32'd0);
    chk("mis_stall", {31'd0, core_stall}, 32'd0);
    tick();
    chk("mis_err_pulse", {31'd0, bus_err}, 32'd0);
    $display("LW   @0011 trapped");
`else
    chk("mis_req",   {31'd0, mem_req},   32'd1);
    chk("mis_addr",  {19'd0, mem_addr},  32'h0004);
    respond(0, 32'hCAFEF00D);
    chk("mis_rdata", core_rdata,         32'hCAFEF00D);
    chk("mis_err",   {31'd0, bus_err},   32'd0);
    $display("LW   @0011 -> %h", core_rdata);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/brq_dmem_bridge.md
BRQ_DMEM_BRIDGE -- requirements
Module: brq_dmem_bridge

Interface
REQ-001 SHALL have parameters: DataWidth 32 (data width); AddrWidth 15 (core byte address width); TimeoutCycles 15 (max cycles to wait for mem_ack, 1..255).
REQ-002 SHALL use one clock; reset is asynchronous and active-high. Ports: brq_clk input 1 (clock); brq_rst input 1 (async active-high reset).
REQ-003 SHALL have core-side ports: core_addr input AddrWidth (byte address); core_wdata input DataWidth (store data, LSB-aligned); core_ren input 1 (load request); core_wen input 1 (store request); core_byte_en input 3 (func3 size code).
REQ-004 SHALL have further core-side ports: core_rdata output DataWidth (extended load result); core_stall output 1 (hold pipeline); bus_err output 1 (one-cycle error pulse).
REQ-005 SHALL have memory-side ports: mem_req output 1; mem_we output 1; mem_addr output AddrWidth-2 (word address); mem_wstrb output 4 (byte lane strobes).
REQ-006 SHALL have further memory-side ports: mem_wdata output DataWidth; mem_rdata input DataWidth; mem_ack input 1 (single-cycle completion).

Function
REQ-007 SHALL implement FSM states IDLE, REQ, WAIT, DONE.
REQ-008 SHALL transition IDLE->REQ on (core_ren|core_wen) and latch addr, wdata, size and direction in that cycle.
REQ-009 SHALL treat core_ren and core_wen both high as a store.
REQ-010 SHALL assert core_stall combinationally in IDLE with a request pending, and in REQ and WAIT; core_stall SHALL be low in DONE.
REQ-011 SHALL hold mem_req high in REQ and WAIT; mem_addr, mem_we, mem_wstrb and mem_wdata SHALL be stable while mem_req is high.
REQ-012 SHALL move REQ->DONE if mem_ack is high in REQ, else REQ->WAIT; WAIT->DONE on mem_ack.
REQ-013 SHALL make the minimum latency request-to-DONE 2 cycles, with a zero-wait memory acking in REQ.
REQ-014 SHALL run a timeout counter cleared on entering REQ and incremented each REQ/WAIT cycle; on reaching TimeoutCycles without ack -> DONE, bus_err pulsed in DONE, core_rdata=0.
REQ-015 SHALL ignore mem_ack outside REQ/WAIT.
REQ-016 SHALL hold core_rdata valid in DONE only; it SHALL be registered from mem_rdata at ack.
REQ-017 SHALL go DONE->IDLE unconditionally; a request present in that IDLE cycle starts a new access.
REQ-018 SHALL apply size codes 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU: select lane by addr[1:0], sign-extend for 000/001, zero-extend for 100/101.
REQ-019 SHALL treat undefined size codes as word access.
REQ-020 SHALL replicate store data across lanes (byte x4, half x2); strobes SHALL be 0001<<addr[1:0] for byte, 0011<<{addr[1],0} for half, 1111 for word; mem_wstrb SHALL be 0000 on loads.

Reset
REQ-021 SHALL, on brq_rst, immediately place the FSM in IDLE and drive mem_req=0, mem_we=0, mem_wstrb=0, mem_addr=0, mem_wdata=0, core_rdata=0, bus_err=0, timeout counter=0; core_stall then follows REQ-010.
REQ-022 SHALL abandon an access cut by reset mid-operation without a response; a late mem_ack is ignored per REQ-015.

Configuration
REQ-023 SHALL recognise macro BRQ_DMEM_MISALIGN_TRAP_EN; when defined, a half access with addr[0]=1 or a word access with addr[1:0]!=0 goes IDLE->DONE directly with no mem_req, bus_err pulsed and core_rdata=0.
REQ-024 SHALL, when BRQ_DMEM_MISALIGN_TRAP_EN is undefined, ignore the misaligned low address bits: half uses addr[1], word uses lanes 1111, and no error is raised.

Structure
REQ-025 SHALL take the FSM state enum, size-code localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU) and strobe width from shared package brq_pkg.
REQ-026 SHALL place lane-select/extension and store-replication/strobe logic in one combinational sub-module, brq_lsu_align.

Verification
REQ-027 SHALL cover: LW at 0x0010, memory acks in REQ, rdata 0xDEADBEEF -> mem_addr 0x0004, stall 1 cycle in IDLE plus 1 in REQ, core_rdata 0xDEADBEEF in DONE.
REQ-028 SHALL cover: LB at 0x0013, mem_rdata 0x80FF_0000 -> core_rdata 0xFFFFFF80; same access as LBU -> 0x00000080.
REQ-029 SHALL cover: SH at 0x0022, wdata 0x0000ABCD -> mem_wstrb 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-030 SHALL cover: load with memory never acking, TimeoutCycles=15 -> DONE after 15 wait cycles, bus_err 1 for 1 cycle, core_rdata 0.
REQ-031 SHALL cover: brq_rst asserted while in WAIT, then mem_ack 1 after release -> FSM IDLE, mem_req 0 at once, no DONE, bus_err 0.
REQ-032 SHALL cover: LW at 0x0011 with macro defined -> no mem_req, bus_err pulse; with macro undefined -> word 0x0004 read normally.
